uart_tx_arbiter: RTL

Shares the single UartTx serializer between two byte producers (requester 0: core MMIO print path; requester 1: debug/status source). It runs in the uart_clk domain, picks a requester round-robin, issues a one-cycle send pulse with the byte to UartTx, then holds off further sends until the frame has left the line. Replaces the direct io_uart[8]/io_uart[7:0] hookup in the top level.

---
 rtl/uart_pkg.sv | 31 +++
 rtl/rr_arbiter2.sv | 19 +
 rtl/uart_tx_arbiter.sv | 116 +++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions used by the TX serializer and the TX arbiter.
//   UART_FRAME_CYCLES : uart_clk cycles one TX frame occupies (start + 8 data + stop)
//   BYTE_W            : width of a UART payload byte
//   uart_arb_state_t  : TX arbiter FSM states
//   uart_byte_t       : one payload byte
//   rr_pick           : two-way round-robin pick used by the arbiter
package uart_pkg;

    localparam int unsigned UART_FRAME_CYCLES = 10;
    localparam int unsigned BYTE_W            = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        WAIT = 2'd2
    } uart_arb_state_t;

    typedef logic [BYTE_W-1:0] uart_byte_t;

    // On a tie the requester that was not served last wins; otherwise the sole valid one.
    function automatic logic rr_pick(input logic [1:0] valid, input logic last_grant);
        logic pick;
        if (valid == 2'b11) begin
            pick = ~last_grant;
        end else begin
            pick = valid[1];
        end
        return pick;
    endfunction

endpackage : uart_pkg

// File: rtl/rr_arbiter2.sv
// Two-requester round-robin arbiter, purely combinational.
// Ports:
//   valid[1:0]   in  request lines
//   last_grant   in  index of the requester served most recently
//   grant        out index chosen this cycle (meaningful only with grant_valid)
//   grant_valid  out at least one requester is valid
module rr_arbiter2
    import uart_pkg::*;
(
    input  logic [1:0] valid,
    input  logic       last_grant,
    output logic       grant,
    output logic       grant_valid
);

    assign grant       = rr_pick(valid, last_grant);
    assign grant_valid = |valid;

endmodule : rr_arbiter2

// File: rtl/uart_tx_arbiter.sv
// Shares one UART TX serializer between two byte producers. Picks a requester
// round-robin, emits a one-cycle send strobe with the byte, then blocks further
// accepts until the frame plus one guard cycle has passed.
// Ports:
//   clk, rst                  uart_clk and asynchronous active-low reset
//   reqN_valid/data/ready     byte handshake per requester (ready is combinational)
//   send                      one-cycle strobe to the serializer
//   data                      byte for the serializer, held until the next accept
//   busy                      high while a frame is being sent or waited out
//   last_grant                index of the requester most recently served
module uart_tx_arbiter
    import uart_pkg::*;
#(
    parameter int unsigned FRAME_CYCLES = UART_FRAME_CYCLES
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req0_valid,
    input  logic [BYTE_W-1:0] req0_data,
    output logic              req0_ready,
    input  logic              req1_valid,
    input  logic [BYTE_W-1:0] req1_data,
    output logic              req1_ready,
    output logic              send,
    output logic [BYTE_W-1:0] data,
    output logic              busy,
    output logic              last_grant
);

    localparam int unsigned      CNT_W    = $clog2(FRAME_CYCLES);
    // SEND occupies one frame cycle and the counter counts down to zero inclusive.
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(FRAME_CYCLES - 2);

    uart_arb_state_t  state;
    uart_arb_state_t  state_nxt;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nxt;
    logic             send_nxt;
    uart_byte_t       data_nxt;
    logic             busy_nxt;
    logic             last_grant_nxt;

    logic             grant;
    logic             grant_valid;

    // Priority rule kept in its own block so it can be tested alone.
    rr_arbiter2 u_rr (
        .valid       ({req1_valid, req0_valid}),
        .last_grant  (last_grant),
        .grant       (grant),
        .grant_valid (grant_valid)
    );

    // State, counter and output registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            cnt        <= '0;
            send       <= 1'b0;
            data       <= '0;
            busy       <= 1'b0;
            last_grant <= 1'b1;
        end else begin
            state      <= state_nxt;
            cnt        <= cnt_nxt;
            send       <= send_nxt;
            data       <= data_nxt;
            busy       <= busy_nxt;
            last_grant <= last_grant_nxt;
        end
    end

    // Next-state, next-output and ready decode.
    always_comb begin
        state_nxt      = state;
        cnt_nxt        = cnt;
        send_nxt       = 1'b0;
        data_nxt       = data;
        busy_nxt       = busy;
        last_grant_nxt = last_grant;
        req0_ready     = 1'b0;
        req1_ready     = 1'b0;

        case (state)
            IDLE: begin
                // Ready follows the granted valid, so a grant is always a transfer.
                if (grant_valid) begin
                    req0_ready     = ~grant;
                    req1_ready     = grant;
                    data_nxt       = grant ? req1_data : req0_data;
                    last_grant_nxt = grant;
                    send_nxt       = 1'b1;
                    busy_nxt       = 1'b1;
                    state_nxt      = SEND;
                end
            end
            SEND: begin
                cnt_nxt   = CNT_LOAD;
                state_nxt = WAIT;
            end
            WAIT: begin
                if (cnt == '0) begin
                    busy_nxt  = 1'b0;
                    state_nxt = IDLE;
                end else begin
                    cnt_nxt = cnt - CNT_W'(1);
                end
            end
            default: begin
                busy_nxt  = 1'b0;
                state_nxt = IDLE;
            end
        endcase
    end

endmodule : uart_tx_arbiter
